alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor of the single-cycle RV32I ALU. It implements the full RV32I register/immediate ALU operation set, including SUB, SRA and correct signed/unsigned compares, at configurable data width. Shifts can optionally run iteratively, trading latency for area. It sits between operand fetch and writeback in the execute stage and decouples both sides with valid/ready handshakes.

## Interface
- XLEN, 32: operand/result width; power of two, 8..64.
- SHIFT_STEP, 0: bits shifted per cycle. 0 selects a single-cycle barrel shifter; otherwise a power of two, 1..XLEN/2.
- clock  in  1  rising-edge clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  global advance; when low, all state and outputs hold.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request this cycle.
- funct3  in  3  RV32I ALU funct3.
- alt  in  1  funct7[5]; selects SUB (funct3 000) or SRA (funct3 101); ignored otherwise.
- operand_a  in  XLEN  rs1 value.
- operand_b  in  XLEN  rs2 value or sign-extended immediate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  registered result.
- busy  out  1  high while the FSM is in BUSY.

## Operation
- FSM states:
  - IDLE: no work held.
  - BUSY: iterative shift in progress.
  - HOLD: result valid, awaiting out_ready.
- Accept = in_valid & in_ready & enable.
- in_ready = enable & (state==IDLE | (state==HOLD & out_ready)). This is a combinational out_ready→in_ready path and allows back-to-back issue.
- On accept, the single-cycle path applies to non-shift ops, to shifts when SHIFT_STEP==0, and to shifts with shamt==0. The result is registered and the FSM goes to HOLD.
- On accept of any other shift, operand_a, direction and arithmetic flag are loaded into a work register, and remaining = shamt. FSM goes to BUSY.
- In BUSY, each enabled cycle shifts by min(SHIFT_STEP, remaining) and decrements remaining by the same amount. When remaining reaches 0, the work register is copied to result and the FSM goes to HOLD.
- In HOLD, if out_ready & enable and there is no accept, the FSM goes to IDLE. If there is a simultaneous accept, the FSM follows the accept rules above.
- Ops, with all arithmetic modulo 2^XLEN and carries discarded:
  - 000: alt ? a−b : a+b.
  - 001: SLL.
  - 010: SLT, signed two's complement; result is 1 or 0, zero-extended.
  - 011: SLTU, unsigned; result is 1 or 0, zero-extended.
  - 100: XOR.
  - 101: alt ? SRA (sign fill) : SRL (zero fill).
  - 110: OR.
  - 111: AND.
- shamt = operand_b[$clog2(XLEN)-1:0]; upper bits of operand_b are ignored for shifts.
- result, funct3 and alt are captured at accept. Input changes after accept have no effect.

## Timing
- Reset values: state=IDLE, result=0, out_valid=0, busy=0, remaining=0. in_ready follows enable after reset.
- Reset asserted mid-BUSY or mid-HOLD aborts the operation; no result is produced.
- Non-shift latency: accept at edge t gives out_valid=1 after edge t.
- Iterative shift latency: accept at edge t gives busy=1 after edge t and out_valid=1 after edge t+ceil(shamt/SHIFT_STEP).
- result and out_valid are stable while out_valid & !out_ready; this is required, not optional.
- enable low freezes the FSM, remaining and result; handshakes do not complete.
- Throughput: one op per cycle for the single-cycle path with out_ready held high.

## Structure
- Shared package alu_pkg:
  - funct3 constants ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - state enum IDLE/BUSY/HOLD.
  - A function computing single-cycle results.
- Sub-module alu_shift_step: combinational shifter over XLEN. Inputs are value, amount (0..SHIFT_STEP), direction and arithmetic flag. It is instantiated once, and reused as the barrel shifter when SHIFT_STEP==0.

## Test plan
- XLEN=32, alt=1, funct3=000, a=5, b=7, out_ready=1 → result 0xFFFFFFFE, one cycle after accept.
- a=0xFFFFFFFF, b=1: SLT → 1; SLTU → 0. SLL with a=1, b=33 → 2 (shamt masked to 1).
- SHIFT_STEP=4, SRA with a=0x80000000, b=9 → busy for 3 cycles, then result 0xFFC00000 and out_valid=1. A shift with shamt=0 → single-cycle, result=a.
- Hold out_ready low for 3 cycles after out_valid → result stable and in_ready=0. Raise out_ready together with in_valid (ADD 2+3) → the next result, 5, is valid on the following cycle with no bubble.
- Pulse reset_n low during BUSY → out_valid=0, result=0 and state IDLE immediately (asynchronous). The next op completes normally.
- Drop enable for 2 cycles mid-BUSY → completion is delayed by exactly 2 cycles with an unchanged result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: funct3 codes, FSM states and
// the single-cycle (non-shift) datapath function.
package alu_pkg;

   localparam logic [2:0] ADD  = 3'b000;
   localparam logic [2:0] SLL  = 3'b001;
   localparam logic [2:0] SLT  = 3'b010;
   localparam logic [2:0] SLTU = 3'b011;
   localparam logic [2:0] XOR  = 3'b100;
   localparam logic [2:0] SRL  = 3'b101;
   localparam logic [2:0] OR   = 3'b110;
   localparam logic [2:0] AND  = 3'b111;

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   // Operands arrive sign-extended to 64 bits; that keeps both the signed and
   // the unsigned ordering of the narrower values, so one function fits any XLEN.
   function automatic logic [63:0] alu_calc(input logic [2:0] f3, input logic alt,
                                            input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r;
      r = 64'd0;
      case (f3)
         ADD:     r = alt ? a - b : a + b;
         SLT:     r = {63'd0, $signed(a) < $signed(b)};
         SLTU:    r = {63'd0, a < b};
         XOR:     r = a ^ b;
         OR:      r = a | b;
         AND:     r = a & b;
         default: r = 64'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between operand fetch, the ALU and writeback.
interface alu_seq_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic            alt;
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;

   modport master (output in_valid, funct3, alt, operand_a, operand_b, out_ready,
                   input  in_ready, out_valid, result);
   modport slave  (input  in_valid, funct3, alt, operand_a, operand_b, out_ready,
                   output in_ready, out_valid, result);
endinterface

// File: rtl/alu_shift_step.sv
// Combinational shifter: one step of an iterative shift, or a full barrel
// shifter when the caller passes the whole shift amount.
module alu_shift_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]         value,
   input  logic [$clog2(XLEN)-1:0] amount,
   input  logic                    left,
   input  logic                    arith,
   output logic [XLEN-1:0]         shifted
);
   logic signed [XLEN-1:0] value_s;
   logic signed [XLEN-1:0] sra_s;
   logic        [XLEN-1:0] sra;

   assign value_s = value;
   assign sra_s   = value_s >>> amount;
   assign sra     = sra_s;
   assign shifted = left  ? (value << amount) :
                    arith ? sra : (value >> amount);
endmodule

// File: rtl/alu_seq.sv
// Handshaked RV32I ALU with optional iterative shifter; results wait in HOLD
// until the consumer takes them.
module alu_seq
   import alu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 0
) (
   input  logic      clock,
   input  logic      reset_n,
   input  logic      enable,
   alu_seq_if.slave  bus,
   output logic      busy
);
   localparam int SW     = $clog2(XLEN);
   localparam int STEP_C = (SHIFT_STEP == 0) ? 1 : SHIFT_STEP;
   localparam logic [SW-1:0] STEP_V = SW'(STEP_C);

   state_t          state, nxt;
   logic [XLEN-1:0] res_q, work_q;
   logic [SW-1:0]   rem_q;
   logic            left_q, arith_q;

   logic [SW-1:0]   shamt, step_amt, sh_amt;
   logic [XLEN-1:0] sh_in, sh_out, single;
   logic [63:0]     calc;
   logic            sh_left, sh_arith;
   logic            is_shift, iter, accept;

   assign shamt    = bus.operand_b[SW-1:0];
   assign is_shift = (bus.funct3 == SLL) || (bus.funct3 == SRL);
   assign iter     = (SHIFT_STEP != 0) && is_shift && (shamt != '0);

   assign bus.in_ready  = enable & ((state == IDLE) | ((state == HOLD) & bus.out_ready));
   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.out_valid = (state == HOLD);
   assign bus.result    = res_q;
   assign busy          = (state == BUSY);

   assign step_amt = (rem_q < STEP_V) ? rem_q : STEP_V;

   // One shifter serves both the work register in BUSY and direct operands otherwise.
   always_comb begin
      sh_in    = bus.operand_a;
      sh_amt   = shamt;
      sh_left  = (bus.funct3 == SLL);
      sh_arith = bus.alt;
      if (state == BUSY) begin
         sh_in    = work_q;
         sh_amt   = step_amt;
         sh_left  = left_q;
         sh_arith = arith_q;
      end
   end

   alu_shift_step #(.XLEN(XLEN)) u_shift (
      .value   (sh_in),
      .amount  (sh_amt),
      .left    (sh_left),
      .arith   (sh_arith),
      .shifted (sh_out)
   );

   assign calc   = alu_calc(bus.funct3, bus.alt,
                            64'(signed'(bus.operand_a)), 64'(signed'(bus.operand_b)));
   assign single = is_shift ? sh_out : calc[XLEN-1:0];

   always_comb begin
      nxt = state;
      if (accept) begin
         nxt = iter ? BUSY : HOLD;
      end else begin
         case (state)
            BUSY:    if (rem_q <= STEP_V) nxt = HOLD;
            HOLD:    if (bus.out_ready) nxt = IDLE;
            default: nxt = state;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         res_q   <= '0;
         work_q  <= '0;
         rem_q   <= '0;
         left_q  <= 1'b0;
         arith_q <= 1'b0;
      end else if (enable) begin
         state <= nxt;
         if (accept) begin
            if (iter) begin
               work_q  <= bus.operand_a;
               rem_q   <= shamt;
               left_q  <= (bus.funct3 == SLL);
               arith_q <= bus.alt;
            end else begin
               res_q <= single;
            end
         end else if (state == BUSY) begin
            work_q <= sh_out;
            rem_q  <= rem_q - step_amt;
            if (rem_q == step_amt) res_q <= sh_out;
         end
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed plus randomized checks of alu_seq (XLEN=32, SHIFT_STEP=4) against
// an arithmetic reference model.
module tb_alu_seq;
   logic clock = 1'b0;
   logic reset_n;
   logic enable;
   logic busy;
   int   passed = 0;
   int   total  = 0;

   alu_seq_if #(.XLEN(32)) bus ();

   alu_seq #(.XLEN(32), .SHIFT_STEP(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (enable),
      .bus     (bus.slave),
      .busy    (busy)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      logic signed [31:0] as;
      sh = b[4:0];
      as = a;
      case (f)
         3'd0: return alt ? a - b : a + b;
         3'd1: return a << sh;
         3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: begin
            if (alt) begin
               as = as >>> sh;
               return as;
            end
            return a >> sh;
         end
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   // Cycles from the accepting edge to the first sample with out_valid high.
   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] b);
      if ((f == 3'd1 || f == 3'd5) && b[4:0] != 5'd0) return 1 + (int'(b[4:0]) + 3) / 4;
      return 1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic issue(input logic [2:0] f, input logic alt, input logic [31:0] a,
                        input logic [31:0] b, input logic ordy);
      @(negedge clock);
      bus.in_valid  = 1'b1;
      bus.funct3    = f;
      bus.alt       = alt;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.out_ready = ordy;
      chk("in_ready_at_issue", 64'(bus.in_ready), 64'd1);
      @(negedge clock);
      bus.in_valid  = 1'b0;
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
   endtask

   task automatic wait_valid(input int start, output int n, output int nb);
      n  = start;
      nb = 0;
      while (!bus.out_valid && n < 60) begin
         if (busy) nb++;
         @(negedge clock);
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input logic alt,
                         input logic [31:0] a, input logic [31:0] b);
      int n, nb;
      issue(f, alt, a, b, 1'b1);
      wait_valid(1, n, nb);
      chk({tag, "_lat"}, 64'(n), 64'(ref_lat(f, b)));
      chk({tag, "_res"}, 64'(bus.result), 64'(ref_alu(f, alt, a, b)));
      chk({tag, "_busy"}, 64'(nb), 64'(ref_lat(f, b) - 1));
   endtask

   initial begin
      int n, nb;
      logic [31:0] held;
      reset_n       = 1'b0;
      enable        = 1'b1;
      bus.in_valid  = 1'b0;
      bus.funct3    = 3'd0;
      bus.alt       = 1'b0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      bus.out_ready = 1'b1;
      #12;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_result",    64'(bus.result),    64'd0);
      chk("rst_busy",      64'(busy),          64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      enable = 1'b0;
      #1 chk("rst_in_ready_en0", 64'(bus.in_ready), 64'd0);
      enable = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;

      run_op("sub",     3'd0, 1'b1, 32'd5,        32'd7);
      chk("sub_value", 64'(bus.result), 64'hFFFF_FFFE);
      run_op("slt",     3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1);
      chk("slt_value", 64'(bus.result), 64'd1);
      run_op("sltu",    3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1);
      chk("sltu_value", 64'(bus.result), 64'd0);
      run_op("sll33",   3'd1, 1'b0, 32'd1,        32'd33);
      chk("sll33_value", 64'(bus.result), 64'd2);
      run_op("sra9",    3'd5, 1'b1, 32'h8000_0000, 32'd9);
      chk("sra9_value", 64'(bus.result), 64'hFFC0_0000);
      run_op("srl0",    3'd5, 1'b0, 32'hDEAD_BEEF, 32'h0000_0020);
      run_op("sll31",   3'd1, 1'b0, 32'h0000_0003, 32'd31);

      for (int i = 0; i < 40; i++) begin
         logic [2:0] f;
         f = 3'($urandom_range(0, 7));
         run_op("rand", f, 1'($urandom), $urandom, $urandom);
      end

      // Backpressure: result must hold, then back-to-back issue with no bubble.
      issue(3'd4, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
      wait_valid(1, n, nb);
      held = 32'h1234_5678 ^ 32'h0F0F_0F0F;
      for (int k = 0; k < 3; k++) begin
         chk("bp_valid",    64'(bus.out_valid), 64'd1);
         chk("bp_result",   64'(bus.result),    64'(held));
         chk("bp_in_ready", 64'(bus.in_ready),  64'd0);
         @(negedge clock);
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.funct3    = 3'd0;
      bus.alt       = 1'b0;
      bus.operand_a = 32'd2;
      bus.operand_b = 32'd3;
      #1 chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clock);
      bus.in_valid = 1'b0;
      chk("b2b_valid",  64'(bus.out_valid), 64'd1);
      chk("b2b_result", 64'(bus.result),    64'd5);

      // Asynchronous reset during an iterative shift.
      issue(3'd5, 1'b0, 32'hF000_0000, 32'd31, 1'b1);
      @(negedge clock);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("arst_result",    64'(bus.result),    64'd0);
      chk("arst_busy",      64'(busy),          64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      run_op("post_rst", 3'd5, 1'b0, 32'hF000_0000, 32'd31);

      // Enable low for two cycles mid-BUSY stretches latency by exactly two.
      issue(3'd5, 1'b1, 32'h8000_0000, 32'd9, 1'b1);
      @(negedge clock);
      enable = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk("en0_busy", 64'(busy), 64'd1);
      enable = 1'b1;
      wait_valid(4, n, nb);
      chk("en0_lat",    64'(n),           64'd6);
      chk("en0_result", 64'(bus.result),  64'hFFC0_0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
